// File: rtl/myfilter_dpc_gen.sv
// myfilter_dpc_gen: datapath sequencer for the myfilter FIR.
// Walks SHIFT -> MAC x NTAPS -> SAT -> EXTOUT for every DECIM-th accepted
// sample, and flags samples that arrive while a computation is in flight.
// Optional build macro: MYFILTER_DPC_PENDING_EN adds a 1-deep pending
// sample slot so that one early sample is queued instead of dropped.
module myfilter_dpc_gen #(
  parameter int NTAPS = 5,
  parameter int DECIM = 1,
  localparam int AW = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_in,
  input  logic          program_in,
  input  logic          extvalid_in,
  output logic [AW-1:0] cmem_addr,
  output logic [1:0]    dmem_cmd,
  output logic [AW-1:0] dmem_addr,
  output logic [4:0]    alu_cmd,
  output logic [1:0]    acc_cmd,
  output logic          extvalid_out,
  output logic          busy_out,
  output logic          overrun_out
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DECIM - 1);

  localparam logic [1:0] DMEM_READ  = 2'b00;
  localparam logic [1:0] DMEM_SHIFT = 2'b10;
  localparam logic [1:0] DMEM_CLEAR = 2'b11;
  localparam logic [4:0] ALU_MU     = 5'b11000;
  localparam logic [4:0] ALU_ADMU   = 5'b11001;
  localparam logic [4:0] ALU_SATA   = 5'b00011;
  localparam logic [1:0] ACC_LOAD   = 2'b01;
  localparam logic [1:0] ACC_CLEAR  = 2'b10;

  typedef enum logic [2:0] {
    STOPPED, PROGRAM, CLEAR, EXTIN, SHIFT, MAC, SAT, EXTOUT
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] k, k_nxt;
  logic [DW-1:0] d, d_nxt;
  logic          overrun, overrun_nxt;
  logic          busy_st;
  logic          arrival;
  logic          pend_now;

`ifdef MYFILTER_DPC_PENDING_EN
  logic          pending, pending_nxt;
  assign pend_now = pending;
`else
  assign pend_now = 1'b0;
`endif

  assign busy_st = (state == SHIFT) || (state == MAC) || (state == SAT);
  assign arrival = extvalid_in && busy_st;

  // Next-state, counter, overrun and pending-slot computation
  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    d_nxt       = d;
    overrun_nxt = overrun;
`ifdef MYFILTER_DPC_PENDING_EN
    pending_nxt = pending;
`endif
    case (state)
      STOPPED: if (enable_in) state_nxt = CLEAR;
      PROGRAM: if (!program_in) state_nxt = enable_in ? CLEAR : STOPPED;
      CLEAR: begin
        d_nxt       = '0;
        overrun_nxt = 1'b0;
        state_nxt   = EXTIN;
      end
      EXTIN:   if (extvalid_in) state_nxt = SHIFT;
      SHIFT: begin
        if (d == D_LAST) begin
          d_nxt     = '0;
          k_nxt     = '0;
          state_nxt = MAC;
        end else begin
          d_nxt     = d + 1'b1;
          state_nxt = pend_now ? SHIFT : EXTIN;
        end
      end
      MAC: begin
        if (k == K_LAST) state_nxt = SAT;
        else             k_nxt     = k + 1'b1;
      end
      SAT:     state_nxt = EXTOUT;
      EXTOUT:  state_nxt = (extvalid_in || pend_now) ? SHIFT : EXTIN;
      default: state_nxt = STOPPED;
    endcase

`ifdef MYFILTER_DPC_PENDING_EN
    // A sample consumed from the slot is replaced by any sample arriving in
    // the same cycle; overrun only fires when the slot is already full.
    if (pend_now && (state == EXTOUT || (state == SHIFT && d != D_LAST))) begin
      pending_nxt = extvalid_in;
    end else if (arrival) begin
      if (pending) overrun_nxt = 1'b1;
      else         pending_nxt = 1'b1;
    end
    if (state == STOPPED || state == PROGRAM || state == CLEAR) pending_nxt = 1'b0;
`else
    if (arrival) overrun_nxt = 1'b1;
`endif

    if (program_in)      state_nxt = PROGRAM;
    else if (!enable_in) state_nxt = STOPPED;
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= STOPPED;
      k       <= '0;
      d       <= '0;
      overrun <= 1'b0;
`ifdef MYFILTER_DPC_PENDING_EN
      pending <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      d       <= d_nxt;
      overrun <= overrun_nxt;
`ifdef MYFILTER_DPC_PENDING_EN
      pending <= pending_nxt;
`endif
    end
  end

  // Moore command decode from registered state and tap counter
  always_comb begin
    cmem_addr    = '0;
    dmem_addr    = '0;
    dmem_cmd     = DMEM_READ;
    alu_cmd      = '0;
    acc_cmd      = '0;
    extvalid_out = 1'b0;
    case (state)
      CLEAR: begin
        dmem_cmd = DMEM_CLEAR;
        acc_cmd  = ACC_CLEAR;
      end
      SHIFT: dmem_cmd = DMEM_SHIFT;
      MAC: begin
        cmem_addr = k;
        dmem_addr = k;
        dmem_cmd  = DMEM_READ;
        acc_cmd   = ACC_LOAD;
        alu_cmd   = (k == '0) ? ALU_MU : ALU_ADMU;
      end
      SAT: begin
        alu_cmd = ALU_SATA;
        acc_cmd = ACC_LOAD;
      end
      EXTOUT:  extvalid_out = 1'b1;
      default: ;
    endcase
  end

  assign busy_out    = busy_st;
  assign overrun_out = overrun;

endmodule

// File: tb/tb_myfilter_dpc_gen.sv
// Directed bench for myfilter_dpc_gen: three instances (5 taps/decim 1,
// 5 taps/decim 3, 8 taps/decim 1) share the control inputs.
module tb_myfilter_dpc_gen;

  logic clk = 1'b0;
  logic rst_n, enable_in, program_in, extvalid_in;

  logic [2:0] a_cmem, a_daddr, b_cmem, b_daddr, c_cmem, c_daddr;
  logic [1:0] a_dcmd, a_acc, b_dcmd, b_acc, c_dcmd, c_acc;
  logic [4:0] a_alu, b_alu, c_alu;
  logic       a_ev, a_busy, a_ovr, b_ev, b_busy, b_ovr, c_ev, c_busy, c_ovr;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MYFILTER_DPC_PENDING_EN
  localparam int OVR_SINGLE = 0;
  localparam int OUTS_T4    = 2;
`else
  localparam int OVR_SINGLE = 1;
  localparam int OUTS_T4    = 1;
`endif

  always #5 clk = ~clk;

  myfilter_dpc_gen #(.NTAPS(5), .DECIM(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .program_in(program_in),
    .extvalid_in(extvalid_in), .cmem_addr(a_cmem), .dmem_cmd(a_dcmd),
    .dmem_addr(a_daddr), .alu_cmd(a_alu), .acc_cmd(a_acc),
    .extvalid_out(a_ev), .busy_out(a_busy), .overrun_out(a_ovr));

  myfilter_dpc_gen #(.NTAPS(5), .DECIM(3)) u_b (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .program_in(program_in),
    .extvalid_in(extvalid_in), .cmem_addr(b_cmem), .dmem_cmd(b_dcmd),
    .dmem_addr(b_daddr), .alu_cmd(b_alu), .acc_cmd(b_acc),
    .extvalid_out(b_ev), .busy_out(b_busy), .overrun_out(b_ovr));

  myfilter_dpc_gen #(.NTAPS(8), .DECIM(1)) u_c (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .program_in(program_in),
    .extvalid_in(extvalid_in), .cmem_addr(c_cmem), .dmem_cmd(c_dcmd),
    .dmem_addr(c_daddr), .alu_cmd(c_alu), .acc_cmd(c_acc),
    .extvalid_out(c_ev), .busy_out(c_busy), .overrun_out(c_ovr));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, CLEAR cycle; returns in EXTIN.
  task automatic do_reset();
    rst_n = 1'b0; enable_in = 1'b1; program_in = 1'b0; extvalid_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
  endtask

  initial begin
    int cnt_ev, cnt_mac, n;

    // 1: reset state, then CLEAR, then EXTIN
    rst_n = 1'b0; enable_in = 1'b1; program_in = 1'b0; extvalid_in = 1'b0;
    tick(); tick();
    check("rst_cmem", a_cmem, 0);
    check("rst_dcmd", a_dcmd, 0);
    check("rst_daddr", a_daddr, 0);
    check("rst_alu", a_alu, 0);
    check("rst_acc", a_acc, 0);
    check("rst_ev", a_ev, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ovr", a_ovr, 0);
    rst_n = 1'b1;
    tick();
    check("clr_dcmd", a_dcmd, 2'b11);
    check("clr_acc", a_acc, 2'b10);
    tick();
    check("extin_dcmd", a_dcmd, 0);
    check("extin_acc", a_acc, 0);
    check("extin_busy", a_busy, 0);

    // 2: single sample, NTAPS=5 DECIM=1
    extvalid_in = 1'b1;
    tick();
    extvalid_in = 1'b0;
    check("t2_shift_dcmd", a_dcmd, 2'b10);
    check("t2_shift_busy", a_busy, 1);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_mac%0d_cmem", i), a_cmem, i);
      check($sformatf("t2_mac%0d_daddr", i), a_daddr, i);
      check($sformatf("t2_mac%0d_dcmd", i), a_dcmd, 0);
      check($sformatf("t2_mac%0d_alu", i), a_alu, (i == 0) ? 5'b11000 : 5'b11001);
      check($sformatf("t2_mac%0d_acc", i), a_acc, 2'b01);
      check($sformatf("t2_mac%0d_ev", i), a_ev, 0);
    end
    tick();
    check("t2_sat_alu", a_alu, 5'b00011);
    check("t2_sat_acc", a_acc, 2'b01);
    check("t2_sat_ev", a_ev, 0);
    tick();
    check("t2_extout_ev", a_ev, 1);
    check("t2_extout_busy", a_busy, 0);
    check("t2_extout_alu", a_alu, 0);
    tick();
    check("t2_after_ev", a_ev, 0);
    check("t2_ovr", a_ovr, 0);

    // 3: DECIM=3, six sparse samples
    do_reset();
    for (int unsigned s = 1; s <= 6; s++) begin
      extvalid_in = 1'b1;
      tick();
      extvalid_in = 1'b0;
      check($sformatf("t3_s%0d_shift", s), b_dcmd, 2'b10);
      cnt_ev = 0; cnt_mac = 0;
      for (int unsigned j = 0; j < 19; j++) begin
        tick();
        if (b_ev) cnt_ev++;
        if (b_acc == 2'b01 && b_alu != 5'b00011) cnt_mac++;
      end
      check($sformatf("t3_s%0d_mac", s), cnt_mac, (s % 3 == 0) ? 5 : 0);
      check($sformatf("t3_s%0d_ev", s), cnt_ev, (s % 3 == 0) ? 1 : 0);
    end
    check("t3_ovr", b_ovr, 0);

    // 4: sample during MAC k=2
    do_reset();
    extvalid_in = 1'b1;
    tick();
    extvalid_in = 1'b0;
    tick(); tick(); tick();
    check("t4_at_k2", a_cmem, 2);
    extvalid_in = 1'b1;
    tick();
    extvalid_in = 1'b0;
    check("t4_ovr_next", a_ovr, OVR_SINGLE);
    cnt_ev = 0;
    for (int unsigned j = 0; j < 30; j++) begin
      tick();
      if (a_ev) cnt_ev++;
    end
    check("t4_outputs", cnt_ev, OUTS_T4);
    check("t4_ovr_sticky", a_ovr, OVR_SINGLE);

    // 5: program abort during MAC k=3
    do_reset();
    extvalid_in = 1'b1;
    tick();
    extvalid_in = 1'b0;
    tick(); tick();
    extvalid_in = 1'b1;
    tick();
    extvalid_in = 1'b0;
    check("t5_ovr_set", a_ovr, OVR_SINGLE);
    tick();
    check("t5_at_k3", a_cmem, 3);
    program_in = 1'b1;
    tick();
    check("t5_prog_dcmd", a_dcmd, 0);
    check("t5_prog_alu", a_alu, 0);
    check("t5_prog_acc", a_acc, 0);
    check("t5_prog_busy", a_busy, 0);
    cnt_ev = 0;
    for (int unsigned j = 0; j < 3; j++) begin
      tick();
      if (a_ev) cnt_ev++;
    end
    check("t5_prog_no_ev", cnt_ev, 0);
    program_in = 1'b0;
    tick();
    check("t5_clr_dcmd", a_dcmd, 2'b11);
    check("t5_clr_acc", a_acc, 2'b10);
    tick();
    check("t5_extin_ovr", a_ovr, 0);
    check("t5_extin_dcmd", a_dcmd, 0);
    cnt_ev = 0;
    for (int unsigned j = 0; j < 10; j++) begin
      tick();
      if (a_ev || a_busy) cnt_ev++;
    end
    check("t5_idle", cnt_ev, 0);

    // 6: NTAPS=8, extvalid_in held high
    do_reset();
    extvalid_in = 1'b1;
    tick();
    check("t6_shift", c_dcmd, 2'b10);
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t6_mac%0d_addr", i), c_cmem, i);
      check($sformatf("t6_mac%0d_alu", i), c_alu, (i == 0) ? 5'b11000 : 5'b11001);
    end
    tick();
    check("t6_sat", c_alu, 5'b00011);
    tick();
    check("t6_first_ev", c_ev, 1);
    for (int unsigned p = 0; p < 2; p++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!c_ev && n < 20);
      check($sformatf("t6_period%0d", p), n, 11);
    end
    tick();
    check("t6_back2back_shift", c_dcmd, 2'b10);
    extvalid_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/myfilter_dpc_gen.md
Name: myfilter_dpc_gen

Overview:
Parametrised datapath controller (dpc) for the myfilter FIR datapath. It generalises the fixed 5-tap sequencer to any tap count and adds input decimation, overrun detection and back-to-back sample acceptance. It sits between the I2C register block (program/enable control) and the dmem/cmem/alu/acc datapath, and drives one dp_cmd_t-equivalent command per cycle.

Parameters:
NTAPS, 5, number of filter taps; legal range 2..64; sets cmem/dmem depth.
DECIM, 1, decimation factor; legal range 1..16; an output is computed on every DECIM-th accepted sample.
AW, $clog2(NTAPS), localparam, address width of cmem_addr/dmem_addr.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
enable_in  in  1  filter run enable from register block
program_in  in  1  coefficient programming in progress (I2C owns cmem)
extvalid_in  in  1  new input sample present on datapath input this cycle
cmem_addr  out  AW  coefficient memory address
dmem_cmd  out  2  dmem_cmd_t code: READ 00, WRITE 01, SHIFT 10, CLEAR 11
dmem_addr  out  AW  data memory address
alu_cmd  out  5  alu_cmd_t code (NOP 00000, MU 11000, ADMU 11001, SATA 00011)
acc_cmd  out  2  acc_cmd_t code (NOP 00, LOAD 01, CLEAR 10)
extvalid_out  out  1  filtered output valid, one-cycle pulse
busy_out  out  1  high in SHIFT, MAC, SAT
overrun_out  out  1  sticky: sample arrived while it could not be accepted

Behaviour:
- Moore FSM; all command outputs are decoded from registered state, tap counter k and decimation counter d.
- States: STOPPED, PROGRAM, CLEAR, EXTIN, SHIFT, MAC, SAT, EXTOUT.
- Reset (rst_n low at a clk edge): state STOPPED, k=0, d=0, overrun=0. All outputs 0 (NOP encoding), extvalid_out=0, busy_out=0.
- Priority, from any state: program_in=1 -> PROGRAM. Otherwise enable_in=0 -> STOPPED. Any in-flight computation is aborted with no extvalid_out.
- STOPPED: output NOP; enable_in=1 -> CLEAR.
- PROGRAM: output NOP; on program_in=0, go to CLEAR if enable_in=1, else STOPPED.
- CLEAR: one cycle; dmem_cmd=CLEAR, acc_cmd=CLEAR; d<=0, overrun<=0; -> EXTIN.
- EXTIN: output NOP. On extvalid_in=1 -> SHIFT.
- SHIFT: one cycle; dmem_cmd=SHIFT, addresses 0.
  - If d==DECIM-1: d<=0, k<=0, -> MAC.
  - Else: d<=d+1, -> EXTIN.
- MAC: one cycle per tap; cmem_addr=dmem_addr=k, dmem_cmd=READ, acc_cmd=LOAD.
  - alu_cmd=MU when k=0; ADMU when k>0.
  - k==NTAPS-1 -> SAT; else k<=k+1.
- SAT: one cycle; alu_cmd=SATA, acc_cmd=LOAD; -> EXTOUT.
- EXTOUT: extvalid_out=1, other outputs NOP.
  - extvalid_in=1 in this cycle is accepted -> SHIFT (back-to-back).
  - Otherwise -> EXTIN.
- Latency: extvalid_in sampled at edge 0 (d at DECIM-1) gives SHIFT in cycle 1, MAC in cycles 2..NTAPS+1, SAT in NTAPS+2, extvalid_out in cycle NTAPS+3 (8 for NTAPS=5).
- Maximum accepted sample rate without overrun: one sample per NTAPS+3 cycles.
- Overrun: extvalid_in=1 while in SHIFT, MAC or SAT sets overrun_out=1, and the sample is dropped. overrun_out is cleared only by reset or CLEAR. extvalid_in in STOPPED/PROGRAM/CLEAR is ignored and does not set overrun.
- k and d never exceed NTAPS-1 and DECIM-1. With DECIM=1, every accepted sample produces an output.

Optional Feature:
MYFILTER_DPC_PENDING_EN.
- Defined: a 1-deep pending flag captures a sample arriving in SHIFT/MAC/SAT. EXTOUT, or the SHIFT->EXTIN return, with pending=1 goes directly to SHIFT and clears the flag. overrun_out sets only if a sample arrives while pending=1. Pending is cleared by reset, CLEAR, STOPPED and PROGRAM.
- Undefined: no pending flag; behaviour exactly as above.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with enable_in=1 -> all outputs 0, state STOPPED; after release, one CLEAR cycle (dmem_cmd=11, acc_cmd=10), then EXTIN.
2. NTAPS=5, DECIM=1: single extvalid_in pulse -> SHIFT, then MAC addresses 0,1,2,3,4 (alu 11000, then 11001 x4, acc 01), then SATA, then extvalid_out pulse exactly 8 cycles after the sampling edge.
3. DECIM=3: 6 sparse extvalid_in pulses -> samples 1,2,4,5 give SHIFT only; samples 3 and 6 each give a full MAC sequence; exactly 2 extvalid_out pulses.
4. extvalid_in pulse during MAC k=2 -> overrun_out=1 next cycle and stays set; still exactly one extvalid_out. With PENDING_EN: overrun_out stays 0 and a second output follows 8 cycles after EXTOUT.
5. program_in=1 during MAC k=3 -> PROGRAM next cycle, no extvalid_out. program_in=0 -> one CLEAR cycle, overrun cleared, then EXTIN.
6. NTAPS=8: extvalid_in held high continuously -> addresses 0..7, latency 11, a sample accepted in each EXTOUT cycle, one output every 11 cycles.
